// File: rtl/axi_rd_dma.sv
// axi_rd_dma: AXI4 read-burst DMA master.
// Accepts a command (byte address and beat count). It splits the command into
// INCR bursts that never exceed MAX_BURST beats and never cross a 4 KB page.
// Only one burst is outstanding at a time. Returned R beats pass through a
// single registered valid/ready stage. out_last marks the final beat of the
// whole command.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/ready/addr/len command request (addr low bits ignored)
//   m_ar*                    AXI read-address channel (master side)
//   m_r*                     AXI read-data channel (master side)
//   out_data/valid/ready/last  output beat stream
//   done                     one-cycle pulse once the last beat has been consumed
//   err                      sticky error flag, cleared on the next command accept
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// A valid, once raised, holds its payload stable until that transfer occurs.
module axi_rd_dma #(
  parameter int AXI_AWIDTH = 64,
  parameter int AXI_DWIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_AWIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [3:0]            m_arid,
  output logic [AXI_AWIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic [3:0]            m_rid,
  input  logic [AXI_DWIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic                  m_rlast,
  input  logic [1:0]            m_rresp,
  output logic [AXI_DWIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  localparam int BYTE_SIZE = AXI_DWIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTE_SIZE);
  localparam int BW        = $clog2(MAX_BURST) + 1;  // holds 1..MAX_BURST

  typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;

  state_t                state, state_nxt;
  logic [AXI_AWIDTH-1:0] addr;       // start address of the next burst
  logic [LEN_WIDTH-1:0]  remaining;  // beats not yet requested on AR
  logic [BW-1:0]         beat_cnt;   // beats still expected in current burst

  logic                  ar_fire, r_fire, load_ar;
  logic [AXI_AWIDTH-1:0] cmd_addr_al, src_addr;
  logic [LEN_WIDTH-1:0]  src_rem;
  logic [BW-1:0]         next_beats;
  logic                  unused;

  // Beats of the next burst: limited by what is left, MAX_BURST and the
  // distance to the end of the 4 KB page (addr is beat aligned).
  function automatic logic [BW-1:0] burst_beats(input logic [AXI_AWIDTH-1:0] a,
                                                input logic [LEN_WIDTH-1:0]  rem);
    logic [12:0]          page;
    logic [LEN_WIDTH-1:0] b;
    page = (13'd4096 - {1'b0, a[11:0]}) >> SIZE_LOG2;
    b = LEN_WIDTH'(MAX_BURST);
    if (LEN_WIDTH'(page) < b) b = LEN_WIDTH'(page);
    if (rem < b) b = rem;
    return BW'(b);
  endfunction

  assign m_arid      = 4'd0;
  assign m_arsize    = 3'(SIZE_LOG2);
  assign m_arburst   = 2'b01;
  assign unused      = ^m_rid;
  assign cmd_addr_al = cmd_addr & ~AXI_AWIDTH'(BYTE_SIZE - 1);

  assign ar_fire = m_arvalid & m_arready;
  assign r_fire  = m_rvalid & m_rready;

  // Bursts are launched either straight from the command (IDLE) or from the
  // updated address/remaining registers (end of previous burst).
  assign src_addr   = (state == IDLE) ? cmd_addr_al : addr;
  assign src_rem    = (state == IDLE) ? cmd_len : remaining;
  assign next_beats = burst_beats(src_addr, src_rem);
  assign load_ar    = (state_nxt == AR) && (state != AR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    m_rready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : AR;
      end
      AR: if (ar_fire) state_nxt = DATA;
      DATA: begin
        // Accept a beat whenever the output register is empty or draining.
        m_rready = ~out_valid | out_ready;
        if (m_rvalid && m_rready && beat_cnt == BW'(1))
          state_nxt = (remaining != '0) ? AR : DONE;
      end
      DONE: if (!out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arvalid <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= (state == DONE) && !out_valid;

      if (cmd_ready && cmd_valid) begin
        addr      <= cmd_addr_al;
        remaining <= cmd_len;
        err       <= 1'b0;
      end

      if (load_ar) begin
        m_araddr  <= src_addr;
        m_arlen   <= 8'(next_beats - BW'(1));
        m_arvalid <= 1'b1;
        beat_cnt  <= next_beats;
      end else begin
        if (ar_fire) begin
          m_arvalid <= 1'b0;
          addr      <= addr + (AXI_AWIDTH'(beat_cnt) << SIZE_LOG2);
          remaining <= remaining - LEN_WIDTH'(beat_cnt);
        end
        if (r_fire) beat_cnt <= beat_cnt - BW'(1);
      end

      if (r_fire) begin
        out_data  <= m_rdata;
        out_valid <= 1'b1;
        out_last  <= (beat_cnt == BW'(1)) && (remaining == '0);
        // The beat count ends the burst; rlast is only cross-checked.
        if (m_rresp != 2'b00 || (m_rlast != (beat_cnt == BW'(1))))
          err <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
